// File: rtl/async_fifo_pkg.sv
// Shared defaults and helpers for the asynchronous FIFO read/write side packers.
package async_fifo_pkg;

    localparam int DEFAULT_DSIZE = 8;
    localparam int DEFAULT_RATIO = 4;

    function automatic int lane_width(input int ratio);
        return $clog2(ratio);
    endfunction

endpackage

// File: rtl/fifo_rd_pack.sv
// Read-side FIFO consumer: pops narrow words and packs RATIO of them,
// little-endian, into one wide word on a valid/ready stream.
module fifo_rd_pack
    import async_fifo_pkg::*;
#(
    parameter int DSIZE = DEFAULT_DSIZE,
    parameter int RATIO = DEFAULT_RATIO,
    parameter int LW    = lane_width(RATIO)
) (
    input  logic                   rclk,
    input  logic                   rrst,
    input  logic [DSIZE-1:0]       rdata,
    input  logic                   rempty,
    output logic                   rinc,
    input  logic                   flush,
    output logic [DSIZE*RATIO-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LW-1:0]          lane
);

    logic [DSIZE-1:0]             acc [RATIO-1];
    logic [DSIZE*(RATIO-1)-1:0]   acc_flat;
    logic                         last_lane;
    logic                         stall;
    logic                         completing;

    assign last_lane  = (lane == LW'(RATIO - 1));
    // Only the final lane needs the output register free; earlier lanes keep popping.
    assign stall      = last_lane & out_valid & ~out_ready;
    assign rinc       = ~rrst & ~rempty & ~flush & ~stall;
    assign completing = rinc & last_lane;

    always_comb begin
        acc_flat = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            acc_flat[i*DSIZE +: DSIZE] = acc[i];
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            for (int i = 0; i < RATIO - 1; i++) begin
                acc[i] <= '0;
            end
            lane      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (flush) begin
                lane <= '0;
            end else if (rinc) begin
                if (last_lane) begin
                    out_data <= {rdata, acc_flat};
                    lane     <= '0;
                end else begin
                    for (int i = 0; i < RATIO - 1; i++) begin
                        if (lane == LW'(i)) begin
                            acc[i] <= rdata;
                        end
                    end
                    lane <= lane + LW'(1);
                end
            end

            // A completing pop in the accept cycle refills the register with no bubble.
            if (completing) begin
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_pack.sv
// Self-checking bench for fifo_rd_pack: queue-based reference model, directed scenarios, random traffic.
module tb_fifo_rd_pack;

    localparam int DSIZE = 8;
    localparam int RATIO = 4;
    localparam int LW    = 2;

    logic                   rclk = 1'b0;
    logic                   rrst;
    logic [DSIZE-1:0]       rdata;
    logic                   rempty;
    logic                   rinc;
    logic                   flush;
    logic [DSIZE*RATIO-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [LW-1:0]          lane;

    int errors = 0;
    int checks = 0;

    logic [DSIZE-1:0]       src_q[$];
    bit                     force_empty;

    logic [DSIZE-1:0]       m_part[$];
    bit                     m_valid;
    logic [DSIZE*RATIO-1:0] m_data;
    bit                     m_popped;

    fifo_rd_pack #(.DSIZE(DSIZE), .RATIO(RATIO)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rdata     (rdata),
        .rempty    (rempty),
        .rinc      (rinc),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lane      (lane)
    );

    always #5 rclk = ~rclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_part.delete();
        m_valid = 1'b0;
        m_data  = '0;
    endfunction

    function automatic bit exp_rinc();
        bit blocked;
        blocked = (m_part.size() == RATIO - 1) && m_valid && !out_ready;
        return !rrst && !rempty && !flush && !blocked;
    endfunction

    // Reference model advances on each rising edge from the inputs held across it.
    always @(posedge rclk) begin
        bit pop;
        bit done;
        pop      = exp_rinc();
        done     = 1'b0;
        m_popped = pop;
        if (rrst) begin
            model_reset();
        end else begin
            if (flush) begin
                m_part.delete();
            end else if (pop) begin
                if (m_part.size() == RATIO - 1) begin
                    m_data = '0;
                    for (int i = 0; i < RATIO - 1; i++) begin
                        m_data = m_data | ((DSIZE*RATIO)'(m_part[i]) << (DSIZE * i));
                    end
                    m_data = m_data | ((DSIZE*RATIO)'(rdata) << (DSIZE * (RATIO - 1)));
                    m_valid = 1'b1;
                    done = 1'b1;
                    m_part.delete();
                end else begin
                    m_part.push_back(rdata);
                end
            end
            if (!done && m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare process: outputs checked mid-cycle, away from the active edge.
    always @(negedge rclk) begin
        if (rrst) begin
            model_reset();
        end
        check("rinc", rinc, exp_rinc());
        check("lane", lane, m_part.size());
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
    end

    task automatic apply();
        rempty = force_empty || (src_q.size() == 0);
        rdata  = rempty ? DSIZE'($urandom) : src_q[0];
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
        if (m_popped) begin
            void'(src_q.pop_front());
        end
        apply();
    endtask

    task automatic push_run(input logic [DSIZE-1:0] first, input logic [DSIZE-1:0] step, input int n);
        logic [DSIZE-1:0] v;
        v = first;
        for (int i = 0; i < n; i++) begin
            src_q.push_back(v);
            v = v + step;
        end
    endtask

    initial begin
        rrst        = 1'b1;
        flush       = 1'b0;
        out_ready   = 1'b1;
        force_empty = 1'b0;
        m_popped    = 1'b0;
        model_reset();
        push_run(8'h11, 8'h11, 8);
        apply();

        // Reset with data present.
        repeat (3) tick();
        check("rst_rinc", rinc, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_lane", lane, 0);
        rrst = 1'b0;
        apply();
        #1;
        check("first_pop", rinc, 1'b1);

        // Streaming, then back-pressure.
        repeat (4) tick();
        check("stream_w0", out_data, 32'h44332211);
        check("stream_v0", out_valid, 1'b1);
        out_ready = 1'b0;
        apply();
        repeat (3) tick();
        check("bp_lane", lane, 3);
        check("bp_rinc", rinc, 1'b0);
        check("bp_hold", out_data, 32'h44332211);
        tick();
        check("bp_hold2", out_data, 32'h44332211);
        check("bp_rinc2", rinc, 1'b0);
        out_ready = 1'b1;
        apply();
        #1;
        check("bp_release", rinc, 1'b1);
        tick();
        check("stream_w1", out_data, 32'h88776655);
        check("stream_v1", out_valid, 1'b1);
        tick();
        check("drain_v", out_valid, 1'b0);

        // Empty gaps, word held with out_ready low.
        out_ready = 1'b0;
        push_run(8'hA0, 8'h01, 4);
        for (int i = 0; i < 8; i++) begin
            force_empty = (i % 2) == 1;
            apply();
            tick();
        end
        force_empty = 1'b0;
        apply();
        check("gap_word", out_data, 32'hA3A2A1A0);
        check("gap_valid", out_valid, 1'b1);

        // Flush with a pending completed word.
        push_run(8'h01, 8'h01, 2);
        apply();
        repeat (2) tick();
        check("fl_lane2", lane, 2);
        push_run(8'h10, 8'h01, 4);
        flush = 1'b1;
        apply();
        #1;
        check("fl_rinc", rinc, 1'b0);
        tick();
        check("fl_lane0", lane, 0);
        flush = 1'b0;
        apply();
        repeat (3) tick();
        check("fl_pending", out_data, 32'hA3A2A1A0);
        check("fl_stall", rinc, 1'b0);
        out_ready = 1'b1;
        apply();
        tick();
        check("fl_word", out_data, 32'h13121110);
        check("fl_valid", out_valid, 1'b1);
        tick();

        // Reset at lane 3 with a word pending.
        out_ready = 1'b0;
        push_run(8'h20, 8'h01, 8);
        apply();
        repeat (7) tick();
        check("mr_lane3", lane, 3);
        check("mr_valid1", out_valid, 1'b1);
        rrst = 1'b1;
        apply();
        #1;
        check("mr_valid0", out_valid, 1'b0);
        check("mr_lane0", lane, 0);
        check("mr_rinc", rinc, 1'b0);
        repeat (2) tick();
        check("mr_rinc_held", rinc, 1'b0);
        rrst = 1'b0;
        apply();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            while (src_q.size() < 6) begin
                src_q.push_back(DSIZE'($urandom));
            end
            out_ready   = $urandom_range(0, 3) != 0;
            force_empty = $urandom_range(0, 3) == 0;
            flush       = $urandom_range(0, 15) == 0;
            rrst        = $urandom_range(0, 299) == 0;
            apply();
            tick();
        end
        rrst  = 1'b0;
        flush = 1'b0;
        apply();
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_pack.md
# fifo_rd_pack

Read-side consumer of the asynchronous FIFO, in the read clock domain. Pops DSIZE-bit words whenever the FIFO is non-empty and packs RATIO consecutive words, little-endian, into one wide word. The wide word is presented on a valid/ready stream. Full input throughput is one pop per cycle, with back-pressure from the stream stalling pops only when a completed word cannot be delivered.

## Interface
Parameters:
- DSIZE, 8, width of one FIFO word
- RATIO, 4, words per packed output; power of two, at least 2
- LW, $clog2(RATIO), derived lane-index width; not overridden

Ports:
- rclk  in  1  read-domain clock; all state on rising edge
- rrst  in  1  reset, asynchronous, active-high
- rdata  in  DSIZE  FIFO read data; combinational from the current read address, valid whenever rempty=0
- rempty  in  1  FIFO empty flag (read domain)
- rinc  out  1  pop strobe to FIFO; combinational
- flush  in  1  discard partially packed word
- out_data  out  DSIZE*RATIO  packed word; word 0 in bits [DSIZE-1:0]
- out_valid  out  1  out_data holds a complete packed word
- out_ready  in  1  downstream accepts out_data this cycle
- lane  out  LW  number of words currently held in the partial accumulator

## Operation
Internal state:
- acc[RATIO-1] of DSIZE bits (partial words)
- lane counter
- out_data/out_valid holding register

Pop rule:
- stall = (lane==RATIO-1) & out_valid & ~out_ready
- rinc = ~rrst & ~rempty & ~flush & ~stall

On a pop with lane < RATIO-1:
- acc[lane] <= rdata
- lane <= lane+1

On a pop with lane == RATIO-1:
- out_data <= {rdata, acc[RATIO-2], …, acc[0]}
- out_valid <= 1
- lane <= 0

Output handshake:
- out_valid & out_ready with no completing pop in the same cycle: out_valid <= 0.
- Accept and completing pop in the same cycle: out_valid stays 1 and out_data takes the new word, giving zero-bubble throughput.
- out_data is held stable while out_valid=1 and out_ready=0.

Flush:
- lane <= 0 and acc contents become don't-care.
- No pop occurs in the flush cycle.
- out_valid/out_data are unaffected, so a completed word is never dropped.

Empty: rinc=0 and state is held. rdata is ignored when rempty=1.

## Timing
Reset values:
- out_valid=0, out_data=0, lane=0, acc=0
- rinc=0 combinationally for as long as rrst=1

Reset mid-packing discards the partial word and any undelivered out_data.

Latency:
- Packed word is visible on out_data/out_valid one rclk after the pop of its last (RATIO-th) word.

Throughput:
- With rempty=0 continuously and out_ready=1, one pop every cycle and out_valid asserted one cycle in every RATIO.

Back-pressure:
- Pops continue for lanes 0..RATIO-2 while a word waits.
- The pop of the final lane waits until out_ready=1 or out_valid=0.
- The accumulator therefore never overflows and no FIFO word is lost.

Wrap: lane wraps from RATIO-1 to 0 only on a completing pop or flush.

Flush and rempty=0 in the same cycle: flush wins and rinc=0.

## Structure
- Shared package async_fifo_pkg:
  - default DSIZE
  - default RATIO
  - lane-width helper function (clog2), used by this block and the write-side counterpart
- Single flat module. The accumulator, lane counter and output register are small and tightly coupled, so no sub-module is warranted.
- rinc stays purely combinational so the FIFO read pointer advances in the pop cycle.

## Test plan
- **Reset:** assert rrst with rempty=0 and pattern data present → rinc=0, out_valid=0, lane=0 throughout. Release → first pop on the next cycle.
- **Streaming:** RATIO=4, FIFO supplies 0x11,0x22,0x33,0x44,0x55… with rempty=0 and out_ready=1 → rinc high every cycle, out_data=0x44332211 one cycle after the 4th pop, then 0x88776655 exactly 4 cycles later.
- **Back-pressure:** out_ready=0 after first word completes → three further pops (lane=3), then rinc=0 with rempty=0. out_data stays 0x44332211. Raise out_ready → same cycle pop of 0x88, and the next cycle shows out_data=0x88776655.
- **Empty gaps:** rempty toggles every other cycle while feeding 0xA0..0xA3 → pops only when rempty=0, and out_data=0xA3A2A1A0 after 8 cycles.
- **Flush:** pop 0x01,0x02 (lane=2), then pulse flush with rempty=0 → rinc=0 and lane=0 in that cycle. Next words 0x10..0x13 → out_data=0x13121110. A pending out_valid word is still delivered intact.
- **Mid-operation reset:** rrst asserted at lane=3 with out_valid=1 → immediate out_valid=0 and lane=0, and no rinc while reset is held.
